// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the data-memory responder.
//   state_e        : responder FSM states (IDLE / WAIT / RESP)
//   WORD_OFFSET    : number of byte-offset bits below the word index
//   BYTES_PER_WORD : byte lanes per 32-bit word
//   addr_err()     : misaligned / out-of-range test on a byte address
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WORD_OFFSET    = 2;
  localparam int BYTES_PER_WORD = 4;

  // The caller zero-extends its address to 64 bits, so one function
  // serves every ADDR_W up to 64.
  function automatic logic addr_err(input logic [63:0] byte_addr,
                                    input int unsigned depth_words);
    logic misaligned;
    logic out_of_range;
    misaligned   = (byte_addr[WORD_OFFSET-1:0] != '0);
    out_of_range = ((byte_addr >> WORD_OFFSET) >= 64'(depth_words));
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port RAM of 32-bit words with a registered
// read port and per-byte write mask.
//   clk_i   : clock, rising edge
//   en_i    : access enable for this edge
//   we_i    : 1 = write (masked by be_i), 0 = read into rdata_o
//   addr_i  : word index
//   wdata_i : write data
//   be_i    : byte-lane write mask, lane k = data[8k+7:8k]
//   rdata_o : registered read data; holds until the next read
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    be_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // NOTE: the storage array and its read register have no reset; a RAM
  // macro cannot be cleared in one cycle and the contents must survive a
  // responder reset anyway.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (be_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle MEM-stage data-memory responder.
// Accepts one load/store at a time, completes it LATENCY cycles after
// acceptance with a one-cycle ack, and freezes the pipeline meanwhile.
//   clk_i   : clock, rising edge
//   rst_i   : asynchronous active-low reset
//   req_i   : access request, held until ack
//   we_i    : 1 = store, 0 = load (sampled at accept)
//   addr_i  : byte address (sampled at accept)
//   wdata_i : store data (sampled at accept)
//   be_i    : byte enables, honoured only when DMEM_BYTE_MASK_EN is defined
//   ready_o : high while idle
//   ack_o   : one-cycle completion pulse
//   rdata_o : load data, valid with ack_o and held until the next ack
//   err_o   : pulses with ack_o on a misaligned or out-of-range access
//   stall_o : pipeline freeze request
// Build option: define DMEM_BYTE_MASK_EN to make stores honour be_i;
// otherwise every store writes the full word.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        be_i,
  output logic              ready_o,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  output logic              stall_o
);

  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  // Forces rdata_o to zero after reset and after an errored access, so the
  // RAM read register itself never needs a reset.
  logic                rdata_zero_q, rdata_zero_d;

  // Access presented to the RAM on the edge that enters RESP.
  logic                access_go;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;
  logic [3:0]          acc_be;
  logic                acc_err;
  logic [3:0]          ram_be;
  logic [31:0]         ram_rdata;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    ack_d        = 1'b0;
    err_d        = 1'b0;
    rdata_zero_d = rdata_zero_q;
    access_go    = 1'b0;
    acc_we       = we_q;
    acc_addr     = addr_q;
    acc_wdata    = wdata_q;
    acc_be       = be_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          be_d    = be_i;
          cnt_d   = CNT_LOAD;
          if (LATENCY > 1) begin
            state_d = ST_WAIT;
          end else begin
            // Single-cycle latency: the accept edge is also the RESP-entry
            // edge, so the RAM sees the live request.
            state_d   = ST_RESP;
            access_go = 1'b1;
            acc_we    = we_i;
            acc_addr  = addr_i;
            acc_wdata = wdata_i;
            acc_be    = be_i;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = ST_RESP;
          access_go = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    acc_err = addr_err(64'(acc_addr), DEPTH_WORDS);
    if (access_go) begin
      ack_d = 1'b1;
      err_d = acc_err;
      // Stores leave rdata_o untouched; loads and errors refresh it.
      if (acc_err || !acc_we) rdata_zero_d = acc_err;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      ack_q        <= 1'b0;
      err_q        <= 1'b0;
      rdata_zero_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      rdata_zero_q <= rdata_zero_d;
    end
  end

`ifdef DMEM_BYTE_MASK_EN
  assign ram_be = acc_be;
`else
  logic unused_be;
  assign unused_be = ^acc_be;
  assign ram_be    = 4'b1111;
`endif

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk_i  (clk_i),
    .en_i   (access_go && !acc_err),
    .we_i   (acc_we),
    .addr_i (acc_addr[WORD_OFFSET +: AW]),
    .wdata_i(acc_wdata),
    .be_i   (ram_be),
    .rdata_o(ram_rdata)
  );

  assign ready_o = (state_q == ST_IDLE);
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign rdata_o = rdata_zero_q ? '0 : ram_rdata;
  // Low in RESP so the pipeline advances on the ack edge.
  assign stall_o = ((state_q == ST_IDLE) && req_i) || (state_q == ST_WAIT);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder that sits on the memory side of the pipeline's MEM-stage load/store interface. It accepts one request at a time from the EX/MEM stage, services it after a fixed latency and returns read data with a one-cycle acknowledge. It drives a stall signal back to the hazard logic so PC, IF/ID, ID/EX and EX/MEM hold while an access is outstanding.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, data word width; fixed at 32
DEPTH_WORDS, 1024, number of 32-bit words in the backing array
LATENCY, 4, cycles from request acceptance to ack_o; legal range 1..15

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req_i  in  1  access request (MemRead|MemWrite from EX/MEM); held high until ack
we_i  in  1  1 = store, 0 = load; sampled at accept
addr_i  in  ADDR_W  byte address (ALU result); sampled at accept
wdata_i  in  DATA_W  store data; sampled at accept
be_i  in  4  byte enables; used only with DMEM_BYTE_MASK_EN
ready_o  out  1  high in IDLE only
ack_o  out  1  one-cycle completion pulse
rdata_o  out  DATA_W  load data; valid while ack_o=1, held until the next ack
err_o  out  1  pulses with ack_o on a misaligned or out-of-range access
stall_o  out  1  pipeline freeze request to the hazard unit

Behaviour:
- States: IDLE, WAIT, RESP.
- Reset (rst_i=0, asynchronous): state=IDLE, counter=0. Outputs: ready_o=1, ack_o=0, err_o=0, rdata_o=0, stall_o=0 (stall_o is combinational, so it equals req_i in IDLE). The array is not cleared.
- IDLE:
  - req_i=1 at an edge: latch we/addr/wdata/be and load counter=LATENCY-1.
  - Next state is WAIT if LATENCY>1, else RESP.
- WAIT: counter decrements each cycle. When counter reaches 1 at an edge, next state is RESP.
- Entry edge into RESP does the access:
  - Store: write to the array.
  - Load: register array[word] into rdata_o.
  - Error access: no write; rdata_o=0.
- RESP: ack_o=1 for exactly one cycle, err_o as computed, ready_o=0, stall_o=0. Next state is IDLE unconditionally.
- Timing:
  - Request accepted at edge T; ack_o is high during cycle T+LATENCY.
  - Minimum spacing between accepts is LATENCY+1 edges.
- stall_o = (state==IDLE & req_i) | (state==WAIT). It is low in RESP, so the pipeline advances on the ack edge and captures rdata_o.
- Word index = addr[ADDR_W-1:2].
  - err if addr[1:0]!=0 or index >= DEPTH_WORDS.
  - Computed from the latched address.
- req_i deasserting during WAIT does not cancel the access; it completes normally.
- req_i high during RESP is not accepted until IDLE on the following cycle.
- Reset mid-WAIT: access is dropped and no write occurs. If reset lands after the RESP-entry edge, the write has already occurred.

Optional Feature:
DMEM_BYTE_MASK_EN:
- Defined: stores update only bytes with be_i[k]=1 (byte k = data[8k+7:8k]). be_i=0000 completes the store with ack and writes nothing. Loads ignore be_i.
- Undefined: be_i is ignored; every store writes the full word. Error rules are identical in both builds.

Decomposition:
- dmem_pkg holds: state enum (IDLE/WAIT/RESP), WORD_OFFSET=2, BYTES_PER_WORD=4, and the error-condition function.
- One natural sub-module: dmem_array. It is a synchronous single-port RAM with registered read, write enable and byte-mask input (mask tied to 1111 when the feature is off).
- The FSM, counter, request latch and error check stay in dmem_responder.

Test Plan (all with LATENCY=4):
- Reset, then store addr=0x10, wdata=0xDEADBEEF: stall_o=1 for 4 cycles, ack_o pulses in cycle 4, err_o=0. A following load of 0x10 gives rdata_o=0xDEADBEEF at its ack.
- Load addr=0x12 (misaligned): ack_o and err_o both high at cycle 4, rdata_o=0. The array is unchanged when 0x10 is re-read.
- Load addr=4*DEPTH_WORDS (0x1000): err_o=1, rdata_o=0, no hang.
- Back-to-back loads with req_i held high: accepts are 5 edges apart; exactly two ack pulses within 10 cycles.
- rst_i=0 asserted in the 2nd WAIT cycle of a store of 0x12345678 to 0x20: outputs reset immediately. A later load of 0x20 returns its prior value.
- With DMEM_BYTE_MASK_EN: preload 0xAABBCCDD at 0x30, store 0x11223344 with be_i=0101 -> load returns 0xAA22CC44. Without the macro, the same store returns 0x11223344.
